// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid convolution over an IN_WIDTH x IN_HEIGHT
// frame. Two line buffers and a 3x3 shift window build the neighbourhood of
// each accepted pixel. A two-stage datapath (multiply, then adder tree) gives a
// fixed latency of 2 cycles from the accepting cycle to result_valid.
module conv3x3_stream #(
    parameter int unsigned IN_WIDTH  = 34,
    parameter int unsigned IN_HEIGHT = 34,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned ACC_W     = 22
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_signal,
    input  logic                    weight_valid,
    input  logic signed [PIX_W-1:0] weight_in,
    input  logic                    pixel_valid,
    input  logic signed [PIX_W-1:0] pixel_in,
    output logic signed [ACC_W-1:0] result_out,
    output logic                    result_valid,
    output logic                    done_signal,
    output logic                    busy
);

    localparam int unsigned PROD_W = 2 * PIX_W;
    localparam int unsigned COL_W  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int unsigned ROW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int unsigned NTAP   = 9;
    localparam int unsigned WIDX_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Control state
    logic [1:0]         state_q, state_d;
    logic [WIDX_W-1:0]  w_idx_q, w_idx_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;

    // Kernel, line buffers and window (window index = row*3 + col, row 0 oldest)
    logic signed [PIX_W-1:0]  kern_q   [NTAP];
    logic signed [PIX_W-1:0]  lb_top_q [IN_WIDTH];
    logic signed [PIX_W-1:0]  lb_mid_q [IN_WIDTH];
    logic signed [PIX_W-1:0]  win_q    [NTAP];
    logic signed [PIX_W-1:0]  win_d    [NTAP];

    // Pipeline
    logic signed [PROD_W-1:0] prod_d   [NTAP];
    logic signed [PROD_W-1:0] prod_q   [NTAP];
    logic                     p1_valid_q;
    logic signed [ACC_W-1:0]  sum_c;
    logic signed [ACC_W-1:0]  result_q;
    logic                     result_valid_q;
    logic                     done_q;
    logic                     busy_q;

    // Strobes
    logic start_c;
    logic wr_weight_c;
    logic accept_c;
    logic col_last_c;
    logic row_last_c;
    logic win_ok_c;

    // Qualified control strobes; inputs outside their legal state are dropped here
    always_comb begin
        start_c     = (state_q == S_IDLE) && start_signal;
        wr_weight_c = (state_q == S_IDLE) && weight_valid;
        accept_c    = (state_q == S_STREAM) && pixel_valid;
        col_last_c  = (col_q == COL_W'(IN_WIDTH - 1));
        row_last_c  = (row_q == ROW_W'(IN_HEIGHT - 1));
        win_ok_c    = accept_c && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    end

    // Next-state logic for FSM, weight index and raster counters
    always_comb begin
        state_d = state_q;
        w_idx_d = w_idx_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (weight_valid) begin
                    w_idx_d = (w_idx_q == WIDX_W'(NTAP - 1)) ? '0 : w_idx_q + WIDX_W'(1);
                end
                if (start_signal) begin
                    w_idx_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pixel_valid) begin
                    if (col_last_c) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (col_last_c && row_last_c) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Final product already moved to the adder stage: last result is out now
                if (!p1_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, weight index and raster counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            w_idx_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            w_idx_q <= w_idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Kernel coefficient storage, loaded in raster order while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NTAP; k++) begin
                kern_q[k] <= '0;
            end
        end else if (wr_weight_c) begin
            kern_q[w_idx_q] <= weight_in;
        end
    end

    // Window after shifting in the new column {row r-2, row r-1, row r}
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_d[i*3 + 0] = win_q[i*3 + 1];
            win_d[i*3 + 1] = win_q[i*3 + 2];
        end
        win_d[2] = lb_top_q[col_q];
        win_d[5] = lb_mid_q[col_q];
        win_d[8] = pixel_in;
    end

    // Line buffers and window advance only on accepted pixels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int x = 0; x < IN_WIDTH; x++) begin
                lb_top_q[x] <= '0;
                lb_mid_q[x] <= '0;
            end
            for (int k = 0; k < NTAP; k++) begin
                win_q[k] <= '0;
            end
        end else if (start_c) begin
            for (int x = 0; x < IN_WIDTH; x++) begin
                lb_top_q[x] <= '0;
                lb_mid_q[x] <= '0;
            end
            for (int k = 0; k < NTAP; k++) begin
                win_q[k] <= '0;
            end
        end else if (accept_c) begin
            lb_top_q[col_q] <= lb_mid_q[col_q];
            lb_mid_q[col_q] <= pixel_in;
            for (int k = 0; k < NTAP; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    // Stage 1 products: full-width signed multiply of kernel by the new window
    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            prod_d[k] = PROD_W'(kern_q[k]) * PROD_W'(win_d[k]);
        end
    end

    // Stage 1 register: products captured only for complete windows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid_q <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            p1_valid_q <= win_ok_c;
            if (win_ok_c) begin
                for (int k = 0; k < NTAP; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
        end
    end

    // Stage 2 adder tree over sign-extended products; range fits without saturation
    always_comb begin
        sum_c = ((ACC_W'(prod_q[0]) + ACC_W'(prod_q[1]))
              +  (ACC_W'(prod_q[2]) + ACC_W'(prod_q[3])))
              + ((ACC_W'(prod_q[4]) + ACC_W'(prod_q[5]))
              +  (ACC_W'(prod_q[6]) + ACC_W'(prod_q[7])))
              +   ACC_W'(prod_q[8]);
    end

    // Stage 2 register: result holds its value while not valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= p1_valid_q;
            if (p1_valid_q) begin
                result_q <= sum_c;
            end
        end
    end

    // Status flags registered from the next state so they align with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_DONE);
        end
    end

    assign result_out   = result_q;
    assign result_valid = result_valid_q;
    assign done_signal  = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: randomized and directed frames against a plain-arithmetic
// convolution model, with latency, done-pulse and reset behaviour checks.
module tb_conv3x3_stream;

    localparam int W    = 34;
    localparam int H    = 34;
    localparam int NRES = (W - 2) * (H - 2);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_signal = 1'b0;
    logic weight_valid = 1'b0;
    logic signed [7:0] weight_in = '0;
    logic pixel_valid = 1'b0;
    logic signed [7:0] pixel_in = '0;
    logic signed [21:0] result_out;
    logic result_valid;
    logic done_signal;
    logic busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int img [H][W];
    int kern [9];
    int exp_q [$];
    int got_q [$];
    int got_cyc_q [$];
    int acc_q [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_rv_cyc = 0;
    int hold_viol = 0;
    logic signed [21:0] prev_out = '0;
    logic prev_rst = 1'b0;

    conv3x3_stream #(.IN_WIDTH(W), .IN_HEIGHT(H), .PIX_W(8), .ACC_W(22)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .weight_valid (weight_valid),
        .weight_in    (weight_in),
        .pixel_valid  (pixel_valid),
        .pixel_in     (pixel_in),
        .result_out   (result_out),
        .result_valid (result_valid),
        .done_signal  (done_signal),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture shortly after each rising edge
    always @(posedge clk) begin
        #1;
        if (result_valid) begin
            got_q.push_back(int'(result_out));
            got_cyc_q.push_back(cyc);
            last_rv_cyc = cyc;
        end
        if (done_signal) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst && prev_rst && !result_valid && (result_out !== prev_out)) hold_viol++;
        prev_out = result_out;
        prev_rst = rst;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_capture();
        got_q.delete();
        got_cyc_q.delete();
        acc_q.delete();
        done_cnt = 0;
    endtask

    task automatic fill_const(input int v);
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = v;
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (y * 34 + x) % 128;
    endtask

    task automatic fill_random();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) img[y][x] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic random_kernel();
        for (int k = 0; k < 9; k++) kern[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Valid (unpadded), unflipped 3x3 convolution in output raster order
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
                int s;
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) s += kern[i*3 + j] * img[r + i][c + j];
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic load_weights();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            weight_valid = 1'b1;
            weight_in    = 8'(kern[k]);
        end
        @(negedge clk);
        weight_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        start_signal = 1'b1;
        @(negedge clk);
        start_signal = 1'b0;
    endtask

    // mode 0: back-to-back, 1: every other cycle, 2: random gaps
    task automatic drive_pixels(input int mode, input bit stray, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            int gaps;
            int r;
            int c;
            r = idx / W;
            c = idx % W;
            if (mode == 1) gaps = 1;
            else if (mode == 2) gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            else gaps = 0;
            for (int g = 0; g < gaps; g++) begin
                pixel_valid = 1'b0;
                pixel_in    = 8'($urandom_range(0, 255));
                @(negedge clk);
            end
            pixel_valid = 1'b1;
            pixel_in    = 8'(img[r][c]);
            if (stray && (idx % 300 == 100)) begin
                start_signal = 1'b1;
                weight_valid = 1'b1;
                weight_in    = 8'sd5;
            end
            if (r >= 2 && c >= 2) acc_q.push_back(cyc);
            @(negedge clk);
            start_signal = 1'b0;
            weight_valid = 1'b0;
        end
        pixel_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (result_out !== 22'sd0) begin errors++; $display("FAIL reset_result_out: got %0d expected 0", result_out); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid); end
        checks++; if (done_signal !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_signal); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ones();
        for (int k = 0; k < 9; k++) kern[k] = 1;
        fill_const(1);
        clear_capture();
        load_weights();
        start_frame();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy_stream: got %b expected 1", busy); end
        drive_pixels(0, 1'b0, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL ones_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] != 9) begin errors++; $display("FAIL ones_value[%0d]: got %0d expected 9", i, got_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ones_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_cyc != last_rv_cyc + 1) begin errors++; $display("FAIL ones_done_timing: got cycle %0d expected %0d", done_cyc, last_rv_cyc + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_busy_after: got %b expected 0", busy); end
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL ones_hold: got %0d changes while invalid expected 0", hold_viol); end
    endtask

    task automatic test_centre();
        for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 1 : 0;
        fill_ramp();
        clear_capture();
        load_weights();
        start_frame();
        drive_pixels(0, 1'b0, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL centre_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size() && i < NRES; i++) begin
            checks++;
            if (got_q[i] != img[i / (W - 2) + 1][i % (W - 2) + 1]) begin
                errors++; $display("FAIL centre_value[%0d]: got %0d expected %0d", i, got_q[i], img[i / (W - 2) + 1][i % (W - 2) + 1]);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL centre_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_extremes();
        int want [2];
        int wv [2];
        want[0] = 147456;  wv[0] = -128;
        want[1] = -146304; wv[1] = 127;
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 9; k++) kern[k] = wv[t];
            fill_const(-128);
            clear_capture();
            load_weights();
            start_frame();
            drive_pixels(0, 1'b0, W * H);
            repeat (12) @(negedge clk);
            checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL extreme%0d_count: got %0d expected %0d", t, got_q.size(), NRES); end
            for (int i = 0; i < got_q.size(); i++) begin
                checks++; if (got_q[i] != want[t]) begin errors++; $display("FAIL extreme%0d_value[%0d]: got %0d expected %0d", t, i, got_q[i], want[t]); end
            end
        end
    endtask

    task automatic test_gaps();
        for (int k = 0; k < 9; k++) kern[k] = (k == 4) ? 1 : 0;
        fill_ramp();
        build_expected();
        clear_capture();
        load_weights();
        start_frame();
        drive_pixels(1, 1'b0, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL gaps_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size() && i < NRES; i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL gaps_value[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
            checks++; if (got_cyc_q[i] - acc_q[i] != 2) begin errors++; $display("FAIL gaps_latency[%0d]: got %0d cycles expected 2", i, got_cyc_q[i] - acc_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL gaps_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_midframe_reset();
        int n_before;
        for (int k = 0; k < 9; k++) kern[k] = 1;
        fill_const(1);
        clear_capture();
        load_weights();
        start_frame();
        drive_pixels(0, 1'b0, 500);
        rst = 1'b0;
        #1;
        n_before = got_q.size();
        checks++; if (result_out !== 22'sd0) begin errors++; $display("FAIL midrst_result_out: got %0d expected 0", result_out); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL midrst_result_valid: got %b expected 0", result_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (done_signal !== 1'b0) begin errors++; $display("FAIL midrst_done_low: got %b expected 0", done_signal); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() != n_before) begin errors++; $display("FAIL midrst_no_results: got %0d results expected %0d", got_q.size(), n_before); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got busy %b expected 0", busy); end
        clear_capture();
        load_weights();
        start_frame();
        drive_pixels(0, 1'b0, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL midrst_frame_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++; if (got_q[i] != 9) begin errors++; $display("FAIL midrst_frame_value[%0d]: got %0d expected 9", i, got_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL midrst_frame_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_ignored_inputs();
        random_kernel();
        fill_random();
        build_expected();
        clear_capture();
        load_weights();
        start_frame();
        drive_pixels(0, 1'b1, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL ignore_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size() && i < NRES; i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL ignore_value[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done: got %0d expected 1", done_cnt); end
        // Second frame without reloading: kernel must be unchanged
        fill_random();
        build_expected();
        clear_capture();
        start_frame();
        drive_pixels(0, 1'b0, W * H);
        repeat (12) @(negedge clk);
        checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL persist_count: got %0d expected %0d", got_q.size(), NRES); end
        for (int i = 0; i < got_q.size() && i < NRES; i++) begin
            checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL persist_value[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            random_kernel();
            fill_random();
            build_expected();
            clear_capture();
            load_weights();
            start_frame();
            drive_pixels(2, 1'b0, W * H);
            repeat (12) @(negedge clk);
            checks++; if (got_q.size() != NRES) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", f, got_q.size(), NRES); end
            for (int i = 0; i < got_q.size() && i < NRES; i++) begin
                checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rand%0d_value[%0d]: got %0d expected %0d", f, i, got_q[i], exp_q[i]); end
                checks++; if (got_cyc_q[i] - acc_q[i] != 2) begin errors++; $display("FAIL rand%0d_latency[%0d]: got %0d cycles expected 2", f, i, got_cyc_q[i] - acc_q[i]); end
            end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done: got %0d expected 1", f, done_cnt); end
            checks++; if (done_cyc != last_rv_cyc + 1) begin errors++; $display("FAIL rand%0d_done_timing: got cycle %0d expected %0d", f, done_cyc, last_rv_cyc + 1); end
            checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d changes while invalid expected 0", f, hold_viol); end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_centre();
        test_extremes();
        test_gaps();
        test_midframe_reset();
        test_ignored_inputs();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
